// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the ID/EX hazard controller and its
// register-match helper.
package hazard_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int CNT_W          = 3;   // holds LOAD_LAT-1 for LOAD_LAT up to 7

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  // IF/ID flush loads this instruction (addi x0, x0, 0); the ID/EX bubble
  // is simply an all-zero control word.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_hold;
    logic if_id_hold;
    logic if_id_flush;
    logic id_ex_hold;
    logic id_ex_flush;
    logic redirect;
  } hz_ctl_t;

  localparam hz_ctl_t CTL_IDLE   = hz_ctl_t'(6'b000000);
  localparam hz_ctl_t CTL_FREEZE = hz_ctl_t'(6'b110100);
  localparam hz_ctl_t CTL_REDIR  = hz_ctl_t'(6'b001011);
  localparam hz_ctl_t CTL_BUBBLE = hz_ctl_t'(6'b110010);

endpackage

// File: rtl/hazard_ctrl_match.sv
// Source-vs-destination register comparator with used/x0 qualification.
// Shared between load-use detection and operand forwarding.
module hazard_match #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  qual,
  output logic                  hit
);

  logic rd_live;

  // x0 is hard-wired zero, so a write to it never creates a dependency
  assign rd_live = qual && (rd != '0);
  assign hit     = rd_live && ((rs1_used && (rs1 == rd)) ||
                               (rs2_used && (rs2 == rd)));

endmodule

// File: rtl/hazard_ctrl.sv
// ID/EX hazard control: load-use bubbles, branch/jump squash, external freeze.
// Optional bubble/redirect performance counters enabled by HAZARD_PERF_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int LOAD_LAT   = 1,
  parameter int PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_if_id_i,
  input  logic [REG_ADDR_W-1:0] rs2_if_id_i,
  input  logic                  rs1_used_i,
  input  logic                  rs2_used_i,
  input  logic [REG_ADDR_W-1:0] Rd_id_ex_i,
  input  logic                  MemRead_id_ex_i,
  input  logic                  RegWrite_id_ex_i,
  input  logic                  branch_taken_ex_i,
  input  logic                  jal_id_ex_i,
  input  logic                  jalr_id_ex_i,
  input  logic                  ext_stall_i,
  output logic                  pc_hold_o,
  output logic                  if_id_hold_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_hold_o,
  output logic                  id_ex_flush_o,
  output logic                  redirect_o,
  output logic [PERF_W-1:0]     stall_cnt_o,
  output logic [PERF_W-1:0]     flush_cnt_o
);

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  hz_ctl_t          ctl;
  logic             lu, redir, bubble;

  hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_match (
    .rs1      (rs1_if_id_i),
    .rs2      (rs2_if_id_i),
    .rs1_used (rs1_used_i),
    .rs2_used (rs2_used_i),
    .rd       (Rd_id_ex_i),
    .qual     (MemRead_id_ex_i & RegWrite_id_ex_i),
    .hit      (lu)
  );

  assign redir = branch_taken_ex_i | jal_id_ex_i | jalr_id_ex_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ctl     = CTL_IDLE;
    bubble  = 1'b0;
    if (ext_stall_i) begin
      ctl = CTL_FREEZE;
    end else if (redir) begin
      // a redirect also cancels any stall in progress
      ctl     = CTL_REDIR;
      state_n = RUN;
      cnt_n   = '0;
    end else if (state == STALL) begin
      ctl    = CTL_BUBBLE;
      bubble = 1'b1;
      if (cnt == CNT_W'(1)) begin
        state_n = RUN;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt - CNT_W'(1);
      end
    end else if (lu) begin
      ctl    = CTL_BUBBLE;
      bubble = 1'b1;
      if (LOAD_LAT > 1) begin
        state_n = STALL;
        cnt_n   = CNT_W'(LOAD_LAT - 1);
      end
    end
    if (!rst_n) ctl = CTL_IDLE;
  end

  assign pc_hold_o     = ctl.pc_hold;
  assign if_id_hold_o  = ctl.if_id_hold;
  assign if_id_flush_o = ctl.if_id_flush;
  assign id_ex_hold_o  = ctl.id_ex_hold;
  assign id_ex_flush_o = ctl.id_ex_flush;
  assign redirect_o    = ctl.redirect;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cnt, flush_cnt;

  // bubble/redirect are only raised with ext_stall_i low, so no extra gating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bubble && (stall_cnt != '1)) stall_cnt <= stall_cnt + PERF_W'(1);
      if (ctl.redirect && (flush_cnt != '1)) flush_cnt <= flush_cnt + PERF_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  logic unused_perf;
  assign unused_perf = bubble;
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LOAD_LAT=1 and 3) on shared inputs,
// vector table, directed multi-cycle sequences and random traffic vs a model.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rs1, rs2, rd;
  logic u1, u2, mr, rw, br, jal, jalr, ext;

  logic [5:0]  o1, o3;
  logic [31:0] sc1, fc1, sc3, fc3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(1), .PERF_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .rs1_if_id_i(rs1), .rs2_if_id_i(rs2), .rs1_used_i(u1), .rs2_used_i(u2),
    .Rd_id_ex_i(rd), .MemRead_id_ex_i(mr), .RegWrite_id_ex_i(rw),
    .branch_taken_ex_i(br), .jal_id_ex_i(jal), .jalr_id_ex_i(jalr),
    .ext_stall_i(ext),
    .pc_hold_o(o1[5]), .if_id_hold_o(o1[4]), .if_id_flush_o(o1[3]),
    .id_ex_hold_o(o1[2]), .id_ex_flush_o(o1[1]), .redirect_o(o1[0]),
    .stall_cnt_o(sc1), .flush_cnt_o(fc1)
  );

  hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(3), .PERF_W(32)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .rs1_if_id_i(rs1), .rs2_if_id_i(rs2), .rs1_used_i(u1), .rs2_used_i(u2),
    .Rd_id_ex_i(rd), .MemRead_id_ex_i(mr), .RegWrite_id_ex_i(rw),
    .branch_taken_ex_i(br), .jal_id_ex_i(jal), .jalr_id_ex_i(jalr),
    .ext_stall_i(ext),
    .pc_hold_o(o3[5]), .if_id_hold_o(o3[4]), .if_id_flush_o(o3[3]),
    .id_ex_hold_o(o3[2]), .id_ex_flush_o(o3[1]), .redirect_o(o3[0]),
    .stall_cnt_o(sc3), .flush_cnt_o(fc3)
  );

  // Output word order: {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, redirect}
  localparam logic [5:0] E_IDLE = 6'b000000;
  localparam logic [5:0] E_FRZ  = 6'b110100;
  localparam logic [5:0] E_RED  = 6'b001011;
  localparam logic [5:0] E_BUB  = 6'b110010;

  // Reference model: remaining bubbles owed plus event tallies per instance
  int          lat[2] = '{1, 3};
  int          owed[2];
  logic [31:0] m_sc[2], m_fc[2];

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, rw, br, jal, jalr, ext;
    logic [5:0] exp;
  } vec_t;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_lu();
    return mr && rw && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
  endfunction

  function automatic logic [5:0] m_out(input int k);
    if (!rst_n) return E_IDLE;
    if (ext) return E_FRZ;
    if (br || jal || jalr) return E_RED;
    if (owed[k] > 0 || m_lu()) return E_BUB;
    return E_IDLE;
  endfunction

  function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef HAZARD_PERF_EN
    return v;
`else
    return (v & 32'h0);
`endif
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic m_clear();
    for (int k = 0; k < 2; k++) begin
      owed[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end
  endtask

  task automatic m_step();
    for (int k = 0; k < 2; k++) begin
      if (ext) ;
      else if (br || jal || jalr) begin
        owed[k] = 0; m_fc[k] = sat_inc(m_fc[k]);
      end else if (owed[k] > 0) begin
        owed[k]--; m_sc[k] = sat_inc(m_sc[k]);
      end else if (m_lu()) begin
        owed[k] = lat[k] - 1; m_sc[k] = sat_inc(m_sc[k]);
      end
    end
  endtask

  task automatic drive(input vec_t v);
    rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; u1 = v.u1; u2 = v.u2;
    mr = v.mr; rw = v.rw; br = v.br; jal = v.jal; jalr = v.jalr; ext = v.ext;
  endtask

  task automatic quiet();
    rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; mr = 0; rw = 0;
    br = 0; jal = 0; jalr = 0; ext = 0;
  endtask

  task automatic lu_in();
    quiet(); rs1 = 5; u1 = 1; rd = 5; mr = 1; rw = 1;
  endtask

  task automatic settle();
    #4;
  endtask

  // compare both instances against the model, then cross the clock edge
  task automatic tick();
    if (!rst_n) m_clear();
    cmp("dut1_out", {26'd0, o1}, {26'd0, m_out(0)});
    cmp("dut3_out", {26'd0, o3}, {26'd0, m_out(1)});
    cmp("dut1_stall_cnt", sc1, perf(m_sc[0]));
    cmp("dut3_stall_cnt", sc3, perf(m_sc[1]));
    cmp("dut1_flush_cnt", fc1, perf(m_fc[0]));
    cmp("dut3_flush_cnt", fc3, perf(m_fc[1]));
    @(posedge clk);
    if (rst_n) m_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; quiet();
    settle(); tick();
    rst_n = 1'b1;
  endtask

  vec_t tbl[$];

  initial begin
    rst_n = 1'b0;
    m_clear();
    // reset state with hazard, redirect and freeze inputs all active
    lu_in(); br = 1; ext = 1;
    #7;
    cmp("rst_outs_dut1", {26'd0, o1}, 32'd0);
    cmp("rst_outs_dut3", {26'd0, o3}, 32'd0);
    cmp("rst_stall_cnt", sc3, 32'd0);
    cmp("rst_flush_cnt", fc3, 32'd0);
    tick();
    rst_n = 1'b1; quiet();

    // ---- vector table on the LOAD_LAT=1 instance (no carried state) ----
    tbl.push_back('{"lu_rs1",      5, 0, 5, 1, 0, 1, 1, 0, 0, 0, 0, E_BUB});
    tbl.push_back('{"after_lu",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE});
    tbl.push_back('{"lu_rs2",      1, 5, 5, 0, 1, 1, 1, 0, 0, 0, 0, E_BUB});
    tbl.push_back('{"x0_rd",       0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, E_IDLE});
    tbl.push_back('{"rs2_unused",  1, 5, 5, 1, 0, 1, 1, 0, 0, 0, 0, E_IDLE});
    tbl.push_back('{"not_load",    5, 5, 5, 1, 1, 0, 1, 0, 0, 0, 0, E_IDLE});
    tbl.push_back('{"no_regwrite", 5, 5, 5, 1, 1, 1, 0, 0, 0, 0, 0, E_IDLE});
    tbl.push_back('{"br_over_lu",  5, 0, 5, 1, 0, 1, 1, 1, 0, 0, 0, E_RED});
    tbl.push_back('{"jal",         0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_RED});
    tbl.push_back('{"jalr",        3, 4, 7, 1, 1, 0, 1, 0, 0, 1, 0, E_RED});
    tbl.push_back('{"ext_over_all",5, 0, 5, 1, 0, 1, 1, 1, 0, 0, 1, E_FRZ});
    tbl.push_back('{"ext_alone",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_FRZ});
    tbl.push_back('{"idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE});
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      settle();
      cmp({"tbl_", tbl[i].name}, {26'd0, o1}, {26'd0, tbl[i].exp});
      tick();
    end

    // ---- LOAD_LAT=3, hazard held: exactly three bubbles ----
    do_reset();
    lu_in();
    for (int i = 0; i < 3; i++) begin
      settle(); cmp("lat3_bubble", {26'd0, o3}, {26'd0, E_BUB}); tick();
    end
    quiet();
    settle();
    cmp("lat3_done", {26'd0, o3}, {26'd0, E_IDLE});
    cmp("lat3_stall_cnt", sc3, perf(32'd3));
    tick();

    // ---- freeze mid-stall: one bubble, 4 frozen, 2 bubbles resume ----
    do_reset();
    lu_in();
    settle(); cmp("frz_first_bubble", {26'd0, o3}, {26'd0, E_BUB}); tick();
    ext = 1;
    for (int i = 0; i < 4; i++) begin
      settle(); cmp("frz_hold", {26'd0, o3}, {26'd0, E_FRZ}); tick();
    end
    quiet();
    for (int i = 0; i < 2; i++) begin
      settle(); cmp("frz_resume", {26'd0, o3}, {26'd0, E_BUB}); tick();
    end
    settle(); cmp("frz_done", {26'd0, o3}, {26'd0, E_IDLE});
    cmp("frz_stall_cnt", sc3, perf(32'd3));
    tick();

    // ---- redirect aborts a stall ----
    do_reset();
    lu_in();
    settle(); tick();
    br = 1;
    settle(); cmp("abort_redir", {26'd0, o3}, {26'd0, E_RED}); tick();
    quiet();
    settle(); cmp("abort_no_residual", {26'd0, o3}, {26'd0, E_IDLE});
    cmp("abort_flush_cnt", fc3, perf(32'd1));
    tick();

    // ---- reset asserted mid-stall ----
    do_reset();
    lu_in();
    settle(); tick();
    rst_n = 1'b0;
    #1;
    cmp("midrst_outs", {26'd0, o3}, 32'd0);
    settle(); tick();
    rst_n = 1'b1; quiet();
    settle();
    cmp("midrst_run", {26'd0, o3}, {26'd0, E_IDLE});
    cmp("midrst_stall_cnt", sc3, 32'd0);
    tick();

    // ---- random traffic against the model ----
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      u1 = ($urandom_range(0, 3) != 0); u2 = ($urandom_range(0, 3) != 0);
      mr = ($urandom_range(0, 2) != 0); rw = ($urandom_range(0, 3) != 0);
      br = ($urandom_range(0, 11) == 0); jal = ($urandom_range(0, 19) == 0);
      jalr = ($urandom_range(0, 19) == 0); ext = ($urandom_range(0, 7) == 0);
      settle();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
